// File: rtl/activation_stage_pkg.sv
// Shared constants for the post-pooling activation stage: default geometry,
// activation-type encodings, FSM state encodings and hard-sigmoid constants.
package activation_stage_pkg;

  localparam int unsigned DWIDTH_DEF       = 8;
  localparam int unsigned MAT_MUL_SIZE_DEF = 4;
  localparam int unsigned MASK_WIDTH_DEF   = 4;

  localparam logic ACT_RELU = 1'b0;
  localparam logic ACT_HSIG = 1'b1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int HSIG_OFFSET = 32;
  localparam int HSIG_MAX    = 64;

endpackage

// File: rtl/activation_stage_act_lane.sv
// Single-lane second-stage datapath: ReLU or hard-sigmoid of one signed lane.
// Masked lanes produce 0 regardless of the selected activation.
module act_lane
  import activation_stage_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  logic [DWIDTH-1:0] x,
  input  logic              act_type,
  input  logic              lane_valid,
  output logic [DWIDTH-1:0] y
);

  localparam logic signed [DWIDTH:0] OFFSET = (DWIDTH+1)'(HSIG_OFFSET);
  localparam logic signed [DWIDTH:0] UPPER  = (DWIDTH+1)'(HSIG_MAX);

  logic signed [DWIDTH:0] x_ext;
  logic signed [DWIDTH:0] t;

  // Select the activation; hard-sigmoid is floor(x/4)+32 clamped to [0, 64].
  always_comb begin
    x_ext = $signed({x[DWIDTH-1], x});
    t     = (x_ext >>> 2) + OFFSET;
    y     = '0;
    if (!lane_valid) begin
      y = '0;
    end else if (act_type == ACT_RELU) begin
      y = x[DWIDTH-1] ? '0 : x;
    end else if (t[DWIDTH]) begin
      y = '0;
    end else if (t > UPPER) begin
      y = UPPER[DWIDTH-1:0];
    end else begin
      y = t[DWIDTH-1:0];
    end
  end

endmodule

// File: rtl/activation_stage.sv
// Element-wise activation stage after pooling. Rows pass through an input
// capture stage, a compute stage and a registered output, counted per tile;
// done_activation tells the controller the tile has fully drained. With the
// stage disabled the whole path is a combinational bypass.
module activation_stage
  import activation_stage_pkg::*;
#(
  parameter int unsigned MAT_MUL_SIZE = MAT_MUL_SIZE_DEF,
  parameter int unsigned DWIDTH       = DWIDTH_DEF,
  parameter int unsigned MASK_WIDTH   = MASK_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable_activation,
  input  logic                           activation_type,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
  output logic                           out_data_available,
  output logic                           done_activation
);

  localparam int unsigned RW = MAT_MUL_SIZE * DWIDTH;
  localparam int unsigned CW = $clog2(MAT_MUL_SIZE) + 1;

  logic [1:0]              state;
  logic [CW-1:0]           row_count;
  logic [CW-1:0]           count_inc;
  logic                    accept;
  logic [RW-1:0]           masked_in;

  logic                    s1_valid;
  logic                    s1_type;
  logic [RW-1:0]           s1_data;
  logic [MAT_MUL_SIZE-1:0] s1_mask;

  logic                    s2_valid;
  logic [RW-1:0]           s2_data;
  logic [RW-1:0]           lane_result;

  logic                    out_valid;
  logic [RW-1:0]           out_reg;

  // Rows are only taken while a tile is open (IDLE or ACTIVE).
  always_comb begin
    accept    = enable_activation && in_data_available && (state == IDLE || state == ACTIVE);
    count_inc = row_count + 1'b1;
  end

  // Zero invalid lanes before capture so they never reach the compute stage.
  always_comb begin
    masked_in = '0;
    for (int unsigned k = 0; k < MAT_MUL_SIZE; k++) begin
      masked_in[k*DWIDTH +: DWIDTH] = validity_mask[k] ? inp_data[k*DWIDTH +: DWIDTH] : '0;
    end
  end

  genvar g;
  generate
    for (g = 0; g < MAT_MUL_SIZE; g++) begin : g_lane
      act_lane #(.DWIDTH(DWIDTH)) u_lane (
        .x          (s1_data[g*DWIDTH +: DWIDTH]),
        .act_type   (s1_type),
        .lane_valid (s1_mask[g]),
        .y          (lane_result[g*DWIDTH +: DWIDTH])
      );
    end
  endgenerate

  // Tile FSM and row counter; disabling the stage returns it to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      row_count <= '0;
    end else if (!enable_activation) begin
      state     <= IDLE;
      row_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_data_available) begin
            row_count <= CW'(1);
            state     <= (MAT_MUL_SIZE == 1) ? DRAIN : ACTIVE;
          end
        end
        ACTIVE: begin
          if (in_data_available) begin
            row_count <= count_inc;
            if (count_inc == CW'(MAT_MUL_SIZE)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid && !s2_valid) state <= DONE;
        end
        DONE: begin
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture, compute and output registers; data is zeroed behind invalid slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_type   <= ACT_RELU;
      s1_data   <= '0;
      s1_mask   <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      out_valid <= 1'b0;
      out_reg   <= '0;
    end else if (!enable_activation) begin
      s1_valid  <= 1'b0;
      s1_type   <= ACT_RELU;
      s1_data   <= '0;
      s1_mask   <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      out_valid <= 1'b0;
      out_reg   <= '0;
    end else begin
      s1_valid  <= accept;
      s1_type   <= accept ? activation_type : ACT_RELU;
      s1_data   <= accept ? masked_in : '0;
      s1_mask   <= accept ? validity_mask[MAT_MUL_SIZE-1:0] : '0;
      s2_valid  <= s1_valid;
      s2_data   <= s1_valid ? lane_result : '0;
      out_valid <= s2_valid;
      out_reg   <= s2_data;
    end
  end

  // Bypass muxes: disabled stage passes inputs straight through.
  always_comb begin
    out_data           = enable_activation ? out_reg : inp_data;
    out_data_available = enable_activation ? out_valid : in_data_available;
    done_activation    = enable_activation ? (state == DONE) : 1'b1;
  end

endmodule

// File: tb/tb_activation_stage.sv
// Self-checking bench for activation_stage: randomized rows against a
// floor-division reference model, tile/done sequencing and reset behaviour.
module tb_activation_stage;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable_activation = 1'b1;
  logic           activation_type = 1'b0;
  logic           in_data_available = 1'b0;
  logic [N*W-1:0] inp_data = '0;
  logic [N-1:0]   validity_mask = '1;
  logic [N*W-1:0] out_data;
  logic           out_data_available;
  logic           done_activation;

  int unsigned passed = 0;
  int unsigned total = 0;
  int unsigned cyc = 0;

  logic [N*W-1:0] exp_data[$];
  logic [N*W-1:0] got_data[$];
  int unsigned    exp_stamp[$];
  int unsigned    got_stamp[$];
  bit             rec_en = 1'b0;
  logic           prev_done = 1'b0;
  int unsigned    done_rises = 0;
  int unsigned    done_stamp = 0;

  activation_stage #(.MAT_MUL_SIZE(N), .DWIDTH(W), .MASK_WIDTH(N)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable_activation  (enable_activation),
    .activation_type    (activation_type),
    .in_data_available  (in_data_available),
    .inp_data           (inp_data),
    .validity_mask      (validity_mask),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .done_activation    (done_activation)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Record every produced row and every done rising edge with its cycle stamp.
  always @(negedge clk) begin
    if (rec_en && out_data_available) begin
      got_data.push_back(out_data);
      got_stamp.push_back(cyc);
    end
    if (rec_en && done_activation && !prev_done) begin
      done_rises++;
      done_stamp = cyc;
    end
    prev_done = done_activation;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Reference activation: ReLU, or floor(x/4)+32 clamped to [0,64].
  function automatic int act_ref(input int x, input bit typ);
    int t;
    if (!typ) return (x < 0) ? 0 : x;
    t = (x >= 0) ? x / 4 : -((-x + 3) / 4);
    t = t + 32;
    if (t < 0) t = 0;
    if (t > 64) t = 64;
    return t;
  endfunction

  function automatic logic [N*W-1:0] exp_row(input logic [N*W-1:0] d, input logic [N-1:0] m, input bit typ);
    logic [N*W-1:0] r;
    logic [W-1:0]   lane;
    int             x;
    r = '0;
    for (int k = 0; k < N; k++) begin
      lane = d[k*W +: W];
      x = $signed(lane);
      if (m[k]) r[k*W +: W] = W'(act_ref(x, typ));
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one row for one edge; a row expected to be taken appears 3 stamps later.
  task automatic drive_row(input logic [N*W-1:0] d, input logic [N-1:0] m, input logic t, input bit expect_out);
    inp_data = d;
    validity_mask = m;
    activation_type = t;
    in_data_available = 1'b1;
    if (expect_out) begin
      exp_data.push_back(exp_row(d, m, t));
      exp_stamp.push_back(cyc + 3);
    end
    @(negedge clk);
    in_data_available = 1'b0;
    inp_data = $urandom;
    validity_mask = 4'($urandom);
    activation_type = 1'($urandom);
  endtask

  // Close any previous tile by disabling for one edge, then start recording.
  task automatic fresh();
    rec_en = 1'b0;
    in_data_available = 1'b0;
    enable_activation = 1'b0;
    @(negedge clk);
    enable_activation = 1'b1;
    exp_data.delete(); exp_stamp.delete();
    got_data.delete(); got_stamp.delete();
    done_rises = 0;
    rec_en = 1'b1;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done_activation) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    inp_data = $urandom;
    in_data_available = 1'b1;
    #1;
    total++; if (out_data !== '0) $display("FAIL reset_data: got %h required 0", out_data); else passed++;
    total++; if (out_data_available !== 1'b0) $display("FAIL reset_avail: got %b required 0", out_data_available); else passed++;
    total++; if (done_activation !== 1'b0) $display("FAIL reset_done: got %b required 0", done_activation); else passed++;
    in_data_available = 1'b0;
  endtask

  task automatic test_bypass();
    logic [N*W-1:0] d;
    logic           a;
    @(negedge clk);
    enable_activation = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 32'h807F_00FF : 32'($urandom);
      a = (i == 0) ? 1'b1 : 1'($urandom);
      inp_data = d;
      in_data_available = a;
      #1;
      total++; if (out_data !== d) $display("FAIL bypass_data%0d: got %h required %h", i, out_data, d); else passed++;
      total++; if (out_data_available !== a) $display("FAIL bypass_avail%0d: got %b required %b", i, out_data_available, a); else passed++;
      total++; if (done_activation !== 1'b1) $display("FAIL bypass_done%0d: got %b required 1", i, done_activation); else passed++;
      @(negedge clk);
    end
    in_data_available = 1'b0;
  endtask

  task automatic test_relu_tile();
    bit seen;
    bit held;
    fresh();
    for (int i = 0; i < 4; i++) drive_row(pack4(-5, 7, 0, -128), 4'hF, 1'b0, 1'b1);
    wait_done(seen);
    idle(2);
    total++; if (seen !== 1'b1) $display("FAIL relu_done_timeout: done=0 required 1"); else passed++;
    total++; if (got_data.size() !== exp_data.size()) $display("FAIL relu_count: got %0d rows required %0d", got_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_stamp[i] !== exp_stamp[i])
        $display("FAIL relu_row%0d: got %h at %0d required %h at %0d", i, got_data[i], got_stamp[i], exp_data[i], exp_stamp[i]);
      else passed++;
    end
    total++;
    if (done_rises !== 1 || done_stamp <= exp_stamp[$] || done_stamp > exp_stamp[$] + 3)
      $display("FAIL relu_done_timing: %0d rises at %0d required 1 rise after %0d", done_rises, done_stamp, exp_stamp[$]);
    else passed++;
    held = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done_activation !== 1'b1) held = 1'b0;
      @(negedge clk);
    end
    total++; if (held !== 1'b1) $display("FAIL relu_done_hold: done dropped required held 1"); else passed++;
    rec_en = 1'b0;
    enable_activation = 1'b0;
    @(negedge clk);
    enable_activation = 1'b1;
    #1;
    total++; if (done_activation !== 1'b0) $display("FAIL relu_done_release: got %b required 0", done_activation); else passed++;
  endtask

  task automatic test_hsig();
    bit seen;
    fresh();
    drive_row(pack4(-128, -3, 0, 127), 4'hF, 1'b1, 1'b1);
    drive_row(pack4(100, 100, -1, -4), 4'hF, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive_row(32'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    wait_done(seen);
    idle(2);
    total++; if (exp_data[0] !== 32'h3F_20_1F_00) $display("FAIL hsig_model_row0: got %h required 3f201f00", exp_data[0]); else passed++;
    total++; if (got_data.size() !== exp_data.size()) $display("FAIL hsig_count: got %0d rows required %0d", got_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_stamp[i] !== exp_stamp[i])
        $display("FAIL hsig_row%0d: got %h at %0d required %h at %0d", i, got_data[i], got_stamp[i], exp_data[i], exp_stamp[i]);
      else passed++;
    end
    total++; if (seen !== 1'b1 || done_rises !== 1) $display("FAIL hsig_done: %0d rises required 1", done_rises); else passed++;
  endtask

  task automatic test_mask();
    bit seen;
    fresh();
    drive_row(pack4(10, 20, 30, 40), 4'b0101, 1'b0, 1'b1);
    drive_row(pack4(0, 0, 0, 0), 4'b1010, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive_row(32'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    wait_done(seen);
    idle(2);
    total++; if (got_data.size() !== exp_data.size()) $display("FAIL mask_count: got %0d rows required %0d", got_data.size(), exp_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_stamp[i] !== exp_stamp[i])
        $display("FAIL mask_row%0d: got %h at %0d required %h at %0d", i, got_data[i], got_stamp[i], exp_data[i], exp_stamp[i]);
      else passed++;
    end
    total++; if (seen !== 1'b1) $display("FAIL mask_done_timeout: done=0 required 1"); else passed++;
  endtask

  task automatic test_gapped();
    bit seen;
    fresh();
    for (int i = 0; i < 4; i++) begin
      drive_row(32'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      if (i < 3) idle($urandom_range(0, 3));
    end
    drive_row(32'($urandom), 4'hF, 1'($urandom), 1'b0);
    wait_done(seen);
    drive_row(32'($urandom), 4'hF, 1'($urandom), 1'b0);
    idle(5);
    total++; if (got_data.size() !== 4) $display("FAIL gap_count: got %0d rows required 4", got_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_stamp[i] !== exp_stamp[i])
        $display("FAIL gap_row%0d: got %h at %0d required %h at %0d", i, got_data[i], got_stamp[i], exp_data[i], exp_stamp[i]);
      else passed++;
    end
    total++; if (seen !== 1'b1 || done_rises !== 1) $display("FAIL gap_done: %0d rises required 1", done_rises); else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    fresh();
    drive_row(pack4(50, 60, 70, 80), 4'hF, 1'b0, 1'b1);
    drive_row(pack4(11, 22, 33, 44), 4'hF, 1'b0, 1'b1);
    idle(1);
    total++; if (out_data_available !== 1'b1) $display("FAIL rstmid_pre_avail: got %b required 1", out_data_available); else passed++;
    #2 reset = 1'b0;
    #1;
    total++; if (out_data !== '0) $display("FAIL rstmid_data: got %h required 0", out_data); else passed++;
    total++; if (out_data_available !== 1'b0) $display("FAIL rstmid_avail: got %b required 0", out_data_available); else passed++;
    @(negedge clk);
    reset = 1'b1;
    exp_data.delete(); exp_stamp.delete();
    got_data.delete(); got_stamp.delete();
    done_rises = 0;
    for (int i = 0; i < 4; i++) drive_row(32'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    wait_done(seen);
    idle(2);
    total++; if (got_data.size() !== 4) $display("FAIL rstmid_count: got %0d rows required 4", got_data.size()); else passed++;
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      total++;
      if (got_data[i] !== exp_data[i] || got_stamp[i] !== exp_stamp[i])
        $display("FAIL rstmid_row%0d: got %h at %0d required %h at %0d", i, got_data[i], got_stamp[i], exp_data[i], exp_stamp[i]);
      else passed++;
    end
    total++; if (seen !== 1'b1 || done_rises !== 1) $display("FAIL rstmid_done: %0d rises required 1", done_rises); else passed++;
  endtask

  initial begin
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    test_bypass();
    test_relu_tile();
    test_hsig();
    test_mask();
    test_gapped();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
